// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the two-requester arbitrated adder.
// Optional signed-overflow output is enabled with ADDER_ARB_OVF_EN.
package adder_arb_pkg;

   localparam int DATA_W_DEF = 64;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef logic req_id_t;

   // Both valid: the requester not granted last wins. One valid: it wins regardless.
   function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t last);
      req_id_t pick;
      if (v0 && v1) begin
         pick = ~last;
      end else begin
         pick = v1;
      end
      return pick;
   endfunction

endpackage

// File: rtl/adder_arb_if.sv
// Request/response bundle for adder_arb; rsp_ovf exists only with ADDER_ARB_OVF_EN.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// producer holds valid and payload until that edge, ready never waits on a transfer.
interface adder_arb_if
   import adder_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic              req0_valid;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req0_ready;

   logic              req1_valid;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req1_ready;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   req_id_t           rsp_id;
   logic              rsp_carry;
`ifdef ADDER_ARB_OVF_EN
   logic              rsp_ovf;
`endif

   state_t            state;

   modport master (
`ifdef ADDER_ARB_OVF_EN
      input  rsp_ovf,
`endif
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      input  rsp_valid, rsp_data, rsp_id, rsp_carry,
      output rsp_ready,
      input  state
   );

   modport slave (
`ifdef ADDER_ARB_OVF_EN
      output rsp_ovf,
`endif
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      output rsp_valid, rsp_data, rsp_id, rsp_carry,
      input  rsp_ready,
      output state
   );

endinterface

// File: rtl/adder.sv
// Plain combinational adder, width W, result modulo 2^W.
module adder #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] out
);

   assign out = a + b;

endmodule

// File: rtl/adder_arb.sv
// Two requesters share one adder through a round-robin arbiter; one-entry result register.
// Defining ADDER_ARB_OVF_EN adds the registered signed-overflow flag rsp_ovf.
module adder_arb
   import adder_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   adder_arb_if.slave  bus
);

   state_t            state;
   req_id_t           last_grant;
   req_id_t           grant;
   req_id_t           rsp_id_q;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] rsp_data_q;
   logic [DATA_W:0]   sum_ext;
   logic              rsp_carry_q;
   logic              can_accept;
   logic              ready0;
   logic              ready1;
   logic              accept;

   // Ready is gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      grant      = rr_pick(bus.req0_valid, bus.req1_valid, last_grant);
      can_accept = rst_n && ((state == EMPTY) || bus.rsp_ready);
      ready0     = can_accept && bus.req0_valid && (grant == 1'b0);
      ready1     = can_accept && bus.req1_valid && (grant == 1'b1);
      accept     = ready0 || ready1;
      op_a       = (grant == 1'b1) ? bus.req1_a : bus.req0_a;
      op_b       = (grant == 1'b1) ? bus.req1_b : bus.req0_b;
   end

   // Zero-extend by one bit so the shared adder's top bit is the carry-out.
   adder #(
      .W (DATA_W + 1)
   ) u_adder (
      .a   ({1'b0, op_a}),
      .b   ({1'b0, op_b}),
      .out (sum_ext)
   );

`ifdef ADDER_ARB_OVF_EN
   logic ovf_next;
   logic rsp_ovf_q;

   assign ovf_next = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                     (sum_ext[DATA_W-1] != op_a[DATA_W-1]);
   assign bus.rsp_ovf = rsp_ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         last_grant  <= 1'b1;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         rsp_carry_q <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
         rsp_ovf_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            rsp_data_q  <= sum_ext[DATA_W-1:0];
            rsp_carry_q <= sum_ext[DATA_W];
            rsp_id_q    <= grant;
            last_grant  <= grant;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_q   <= ovf_next;
`endif
         end
         case (state)
            EMPTY: begin
               if (accept) begin
                  state <= FULL;
               end
            end
            FULL: begin
               // Drain with simultaneous refill keeps the entry FULL.
               if (!accept && bus.rsp_ready) begin
                  state <= EMPTY;
               end
            end
         endcase
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rsp_valid  = (state == FULL);
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_carry  = rsp_carry_q;
   assign bus.state      = state;

endmodule
